// File: rtl/debounce_multi_if.sv
// Pin-side bundle for the multi-channel debouncer: raw pins in, debounced level and strobes out.
// master drives the pins and watches the results; slave is the debouncer itself.
interface debounce_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] db_in;
    logic [CHANNELS-1:0] db_state;
    logic [CHANNELS-1:0] db_press;
    logic [CHANNELS-1:0] db_release;
    logic [CHANNELS-1:0] db_long;

    modport master (
        output db_in,
        input  db_state, db_press, db_release, db_long
    );

    modport slave (
        input  db_in,
        output db_state, db_press, db_release, db_long
    );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel synchroniser, stability counter, level plus press/release/long strobes.
// Latency: SYNC_STAGES+DB_CYCLES-1 edges from first pin capture to db_state flip; db_long HOLD_CYCLES after db_press.
// Backpressure: none; outputs are free-running levels and single-cycle registered strobes.
module debounce_multi #(
    parameter int CHANNELS    = 4,
    parameter int CLK_FREQ    = 50000000,
    parameter int DEBOUNCE_MS = 10,
    parameter int HOLD_MS     = 1000,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    debounce_multi_if.slave bus
);

    localparam int DB_CYCLES   = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int HOLD_CYCLES = CLK_FREQ / 1000 * HOLD_MS;
    localparam int CNT_W       = $clog2(DB_CYCLES + 1);

    logic [CHANNELS-1:0] state_vec;
    logic [CHANNELS-1:0] press_vec;
    logic [CHANNELS-1:0] release_vec;
    logic [CHANNELS-1:0] long_vec;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic                   pin;
        logic                   s;
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   state_q, state_d;
        logic                   press_q, press_d;
        logic                   release_q, release_d;

        // Polarity is normalised before the synchroniser so reset value 0 always means released.
        assign pin = (ACTIVE_LOW != 0) ? ~bus.db_in[ch] : bus.db_in[ch];
        assign s   = sync_q[SYNC_STAGES-1];

        always_comb begin
            sync_d    = {sync_q[SYNC_STAGES-2:0], pin};
            cnt_d     = '0;
            state_d   = state_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (s != state_q) begin
                if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                    state_d   = s;
                    press_d   = s;
                    release_d = ~s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q    <= '0;
                cnt_q     <= '0;
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync_q    <= sync_d;
                cnt_q     <= cnt_d;
                state_q   <= state_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign state_vec[ch]   = state_q;
        assign press_vec[ch]   = press_q;
        assign release_vec[ch] = release_q;

        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

            logic [HOLD_W-1:0] hcnt_q, hcnt_d;
            logic              long_q, long_d;

            // Saturation at HOLD_CYCLES is what keeps db_long to one pulse per press.
            always_comb begin
                hcnt_d = '0;
                long_d = 1'b0;
                if (state_q) begin
                    hcnt_d = (hcnt_q == HOLD_W'(HOLD_CYCLES)) ? hcnt_q : hcnt_q + 1'b1;
                    long_d = (hcnt_q == HOLD_W'(HOLD_CYCLES - 1));
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hcnt_q <= '0;
                    long_q <= 1'b0;
                end else begin
                    hcnt_q <= hcnt_d;
                    long_q <= long_d;
                end
            end

            assign long_vec[ch] = long_q;
        end else begin : g_no_hold
            assign long_vec[ch] = 1'b0;
        end
    end

    assign bus.db_state   = state_vec;
    assign bus.db_press   = press_vec;
    assign bus.db_release = release_vec;
    assign bus.db_long    = long_vec;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: an active-high and an active-low instance checked every cycle against a
// sliding-window reference model, plus a vector table and directed corner-case sequences.
module tb_debounce_multi;

    localparam int CH   = 4;
    localparam int DB   = 10;
    localparam int HOLD = 50;
    localparam int SYNC = 2;
    localparam int WIN  = SYNC + DB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] pin_hi;
    logic [CH-1:0] pin_lo;

    always #5 clk = ~clk;

    debounce_multi_if #(.CHANNELS(CH)) if_hi ();
    debounce_multi_if #(.CHANNELS(CH)) if_lo ();

    assign if_hi.db_in = pin_hi;
    assign if_lo.db_in = pin_lo;

    debounce_multi #(
        .CHANNELS(CH), .CLK_FREQ(10000), .DEBOUNCE_MS(1), .HOLD_MS(5),
        .SYNC_STAGES(SYNC), .ACTIVE_LOW(0)
    ) u_hi (
        .clk(clk), .rst_n(rst_n), .bus(if_hi)
    );

    debounce_multi #(
        .CHANNELS(CH), .CLK_FREQ(10000), .DEBOUNCE_MS(1), .HOLD_MS(5),
        .SYNC_STAGES(SYNC), .ACTIVE_LOW(1)
    ) u_lo (
        .clk(clk), .rst_n(rst_n), .bus(if_lo)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a channel flips once the last DB synchronised samples all disagree with it;
    // the synchronised sample seen at edge k is the pin captured at edge k-SYNC.
    logic [WIN-1:0] hist     [2][CH];
    logic           m_st     [2][CH];
    int             press_at [2][CH];
    logic [CH-1:0]  e_st [2];
    logic [CH-1:0]  e_pr [2];
    logic [CH-1:0]  e_rl [2];
    logic [CH-1:0]  e_lg [2];
    int             edge_no = 0;

    int t_idx;
    int n_press [CH];
    int first_press [CH];
    int n_rel [CH];
    int first_rel [CH];
    int n_long [CH];
    int first_long [CH];
    int n_lo_press [CH];
    int first_lo_press [CH];

    typedef struct {
        logic [CH-1:0] pins;
        int            cycles;
        logic [CH-1:0] st;
        logic [CH-1:0] pr;
        logic [CH-1:0] rl;
        logic [CH-1:0] lg;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                hist[d][c]     = '0;
                m_st[d][c]     = 1'b0;
                press_at[d][c] = -100000;
            end
            e_st[d] = '0;
            e_pr[d] = '0;
            e_rl[d] = '0;
            e_lg[d] = '0;
        end
    endtask

    task automatic model_step(input logic [CH-1:0] ph, input logic [CH-1:0] pl);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                logic p, old, flip;
                p          = (d == 0) ? ph[c] : ~pl[c];
                hist[d][c] = {hist[d][c][WIN-2:0], p};
                old        = m_st[d][c];
                flip       = 1'b1;
                for (int i = SYNC; i < WIN; i++) begin
                    if (hist[d][c][i] == old) flip = 1'b0;
                end
                e_lg[d][c] = old && ((edge_no - press_at[d][c]) == HOLD);
                e_pr[d][c] = flip && !old;
                e_rl[d][c] = flip && old;
                if (flip) begin
                    m_st[d][c] = !old;
                    if (!old) press_at[d][c] = edge_no;
                end
                e_st[d][c] = m_st[d][c];
            end
        end
    endtask

    task automatic compare_all();
        check("hi_state",   32'(if_hi.db_state),   32'(e_st[0]));
        check("hi_press",   32'(if_hi.db_press),   32'(e_pr[0]));
        check("hi_release", 32'(if_hi.db_release), 32'(e_rl[0]));
        check("hi_long",    32'(if_hi.db_long),    32'(e_lg[0]));
        check("lo_state",   32'(if_lo.db_state),   32'(e_st[1]));
        check("lo_press",   32'(if_lo.db_press),   32'(e_pr[1]));
        check("lo_release", 32'(if_lo.db_release), 32'(e_rl[1]));
        check("lo_long",    32'(if_lo.db_long),    32'(e_lg[1]));
    endtask

    task automatic clear_track();
        t_idx = 0;
        for (int c = 0; c < CH; c++) begin
            n_press[c] = 0;     first_press[c] = -1;
            n_rel[c] = 0;       first_rel[c] = -1;
            n_long[c] = 0;      first_long[c] = -1;
            n_lo_press[c] = 0;  first_lo_press[c] = -1;
        end
    endtask

    task automatic track();
        for (int c = 0; c < CH; c++) begin
            if (if_hi.db_press[c] === 1'b1) begin
                if (n_press[c] == 0) first_press[c] = t_idx;
                n_press[c]++;
            end
            if (if_hi.db_release[c] === 1'b1) begin
                if (n_rel[c] == 0) first_rel[c] = t_idx;
                n_rel[c]++;
            end
            if (if_hi.db_long[c] === 1'b1) begin
                if (n_long[c] == 0) first_long[c] = t_idx;
                n_long[c]++;
            end
            if (if_lo.db_press[c] === 1'b1) begin
                if (n_lo_press[c] == 0) first_lo_press[c] = t_idx;
                n_lo_press[c]++;
            end
        end
        t_idx++;
    endtask

    // One clock edge: the model sees the pins present at the edge, outputs are sampled 1 time unit later.
    task automatic tick();
        logic [CH-1:0] ph, pl;
        ph = pin_hi;
        pl = pin_lo;
        @(posedge clk);
        edge_no++;
        if (rst_n) model_step(ph, pl);
        #1;
        compare_all();
        track();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_hi_outputs", 32'({if_hi.db_state, if_hi.db_press, if_hi.db_release, if_hi.db_long}), 32'h0);
        check("rst_lo_outputs", 32'({if_lo.db_state, if_lo.db_press, if_lo.db_release, if_lo.db_long}), 32'h0);
        run(3);
        rst_n = 1'b1;
        clear_track();
    endtask

    function automatic logic [CH-1:0] mask_of(input int cnt [CH]);
        logic [CH-1:0] m;
        for (int c = 0; c < CH; c++) m[c] = (cnt[c] != 0);
        return m;
    endfunction

    initial begin
        rst_n  = 1'b1;
        pin_hi = '0;
        pin_lo = '1;
        clear_track();
        model_reset();

        tbl[0]  = '{4'b0001,  12, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 100, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        tbl[2]  = '{4'b0000,  12, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tbl[3]  = '{4'b0110,   9, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0000,  15, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b1010,  10, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b0000,  14, 4'b0000, 4'b1010, 4'b1010, 4'b0000};
        tbl[7]  = '{4'b1111,  62, 4'b1111, 4'b1111, 4'b0000, 4'b1111};
        tbl[8]  = '{4'b0000,  12, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
        tbl[9]  = '{4'b0100,  30, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0000,  60, 4'b0000, 4'b0000, 4'b0100, 4'b0000};

        #2;
        apply_reset();

        for (int r = 0; r < 11; r++) begin
            pin_hi = tbl[r].pins;
            clear_track();
            run(tbl[r].cycles);
            check($sformatf("row%0d_state", r),   32'(if_hi.db_state),  32'(tbl[r].st));
            check($sformatf("row%0d_press", r),   32'(mask_of(n_press)), 32'(tbl[r].pr));
            check($sformatf("row%0d_release", r), 32'(mask_of(n_rel)),   32'(tbl[r].rl));
            check($sformatf("row%0d_long", r),    32'(mask_of(n_long)),  32'(tbl[r].lg));
        end

        // Single press: strobe exactly on edge 11, once, no other channel.
        apply_reset();
        pin_hi = 4'b0001;
        run(14);
        check("t1_first_press", 32'(first_press[0]), 32'd11);
        check("t1_press_count", 32'(n_press[0]), 32'd1);
        check("t1_other_press", 32'(mask_of(n_press) & 4'b1110), 32'h0);

        // 9-high / 1-low chatter never accumulates enough agreement.
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            pin_hi[1] = 1'b1;
            run(9);
            pin_hi[1] = 1'b0;
            run(1);
        end
        check("t2_press_count", 32'(n_press[1]), 32'd0);
        check("t2_state", 32'(if_hi.db_state[1]), 32'd0);

        // Long hold: press at 11, one db_long 50 cycles later, release 11 edges after the drop.
        apply_reset();
        pin_hi[2] = 1'b1;
        run(80);
        check("t3_first_press", 32'(first_press[2]), 32'd11);
        check("t3_first_long", 32'(first_long[2]), 32'd61);
        check("t3_long_count", 32'(n_long[2]), 32'd1);
        pin_hi[2] = 1'b0;
        clear_track();
        run(15);
        check("t3_first_release", 32'(first_rel[2]), 32'd11);
        pin_hi[2] = 1'b1;
        clear_track();
        run(30);
        pin_hi[2] = 1'b0;
        run(60);
        check("t3_short_long_count", 32'(n_long[2]), 32'd0);
        check("t3_short_release", 32'(n_rel[2]), 32'd1);

        // Simultaneous rise; ch3 drops early and must stay silent.
        apply_reset();
        pin_hi = 4'b1001;
        run(5);
        pin_hi[3] = 1'b0;
        run(15);
        check("t4_ch0_press", 32'(first_press[0]), 32'd11);
        check("t4_ch3_events", 32'(n_press[3] + n_rel[3] + n_long[3]), 32'd0);
        check("t4_other_press", 32'(mask_of(n_press) & 4'b0110), 32'h0);

        // Active-low instance: idle-high pins read as released; a 15-cycle low pulse is a press.
        apply_reset();
        run(20);
        check("t5_idle_state", 32'(if_lo.db_state), 32'h0);
        pin_lo[0] = 1'b0;
        clear_track();
        run(15);
        pin_lo[0] = 1'b1;
        run(15);
        check("t5_first_press", 32'(first_lo_press[0]), 32'd11);
        check("t5_press_count", 32'(n_lo_press[0]), 32'd1);

        // Reset mid-hold on ch2 and mid-count on ch0, then full latency again after release.
        apply_reset();
        pin_hi[2] = 1'b1;
        run(30);
        pin_hi[0] = 1'b1;
        run(8);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_async_state", 32'(if_hi.db_state), 32'h0);
        check("t6_async_strobes", 32'({if_hi.db_press, if_hi.db_release, if_hi.db_long}), 32'h0);
        run(2);
        rst_n = 1'b1;
        clear_track();
        run(20);
        check("t6_ch0_press", 32'(first_press[0]), 32'd11);
        check("t6_ch2_press", 32'(first_press[2]), 32'd11);
        check("t6_no_long", 32'(n_long[2]), 32'd0);

        // Random pin activity on both instances, checked cycle by cycle against the model.
        apply_reset();
        pin_hi = '0;
        pin_lo = '1;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, (c == 3) ? 79 : 11) == 0) pin_hi[c] = ~pin_hi[c];
                if ($urandom_range(0, (c == 3) ? 79 : 11) == 0) pin_lo[c] = ~pin_lo[c];
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
